// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: shared types, default timing and helpers for the latch load sequencer.
// The sequencer walks IDLE -> SETUP -> ENABLE -> HOLD -> IDLE around a bank of
// level-sensitive latches so that d is stable on both sides of the enable window.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } latch_state_t;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_EN_CYCLES    = 2;
  localparam int DEF_HOLD_CYCLES  = 1;

  // Width of the shared phase counter: enough bits to hold the longest phase
  // length minus one, never less than one bit.
  function automatic int cnt_width(input int setup_cycles,
                                   input int en_cycles,
                                   input int hold_cycles);
    int longest;
    int w;
    longest = setup_cycles;
    if (en_cycles > longest) longest = en_cycles;
    if (hold_cycles > longest) longest = hold_cycles;
    w = $clog2(longest + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/latch_load_ctrl_phase_counter.sv
// phase_counter: loadable down-counter with a zero flag.
// The sequencer loads it with (phase length - 1) on entry to each phase and
// leaves the phase in the cycle where the flag reports zero. Once at zero the
// counter parks there, so it reads zero while the sequencer is idle.
module phase_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load has priority; otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_load_ctrl.sv
// latch_load_ctrl: sequences the d/e inputs of a bank of level-sensitive latches.
// A word accepted over valid/ready is driven on d_out, held for SETUP_CYCLES,
// then e_out opens for EN_CYCLES, then d_out is held for HOLD_CYCLES more before
// done pulses. Every output comes straight from a flop so e_out never glitches.
// Optional build macro LATCH_READBACK_EN: compare q_in against d_out in the last
// enable cycle and raise a sticky err on mismatch (cleared by clr_err or rst).
module latch_load_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int EN_CYCLES    = DEF_EN_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] d_out,
  output logic             e_out,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clr_err,
  output logic             err
);

  localparam int CW = cnt_width(SETUP_CYCLES, EN_CYCLES, HOLD_CYCLES);

  // Zero-length phases never load the counter, so their load value is unused.
  localparam logic [CW-1:0] SETUP_LD = (SETUP_CYCLES > 0) ? CW'(SETUP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] EN_LD    = (EN_CYCLES    > 0) ? CW'(EN_CYCLES    - 1) : '0;
  localparam logic [CW-1:0] HOLD_LD  = (HOLD_CYCLES  > 0) ? CW'(HOLD_CYCLES  - 1) : '0;

  // An enable window of zero cycles would never load the latches at all.
  if (EN_CYCLES < 1) begin : g_bad_en_cycles
    $error("latch_load_ctrl: EN_CYCLES must be at least 1");
  end
  if (SETUP_CYCLES < 0 || HOLD_CYCLES < 0) begin : g_bad_phase_cycles
    $error("latch_load_ctrl: SETUP_CYCLES and HOLD_CYCLES must not be negative");
  end

  latch_state_t     state_q;
  latch_state_t     state_d;
  logic [WIDTH-1:0] d_out_q;
  logic [WIDTH-1:0] d_out_d;
  logic             e_out_q;
  logic             e_out_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             ready_q;
  logic             ready_d;

  logic             accept;
  logic             cnt_load;
  logic [CW-1:0]    cnt_load_val;
  logic             cnt_zero;

  assign accept = valid && ready_q;

  phase_counter #(
    .CW (CW)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  // Next-state logic: advance when the phase counter hits zero, skipping empty phases.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_load = 1'b1;
          if (SETUP_CYCLES > 0) begin
            state_d      = SETUP;
            cnt_load_val = SETUP_LD;
          end else begin
            state_d      = ENABLE;
            cnt_load_val = EN_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d      = ENABLE;
          cnt_load     = 1'b1;
          cnt_load_val = EN_LD;
        end
      end
      ENABLE: begin
        if (cnt_zero) begin
          if (HOLD_CYCLES > 0) begin
            state_d      = HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop, not a state decode.
  always_comb begin
    d_out_d = d_out_q;
    if (accept) begin
      d_out_d = din;
    end
    e_out_d = (state_d == ENABLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q != IDLE) && (state_d == IDLE);
    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops e_out and clears d_out immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_out_q <= '0;
      e_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      e_out_q <= e_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign d_out = d_out_q;
  assign e_out = e_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef LATCH_READBACK_EN
  logic err_q;
  logic err_d;

  // Sticky readback error: a mismatch in the last enable cycle beats a same-edge clear.
  always_comb begin
    err_d = err_q;
    if (clr_err) begin
      err_d = 1'b0;
    end
    if ((state_q == ENABLE) && cnt_zero && (q_in != d_out_q)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_readback;
  assign unused_readback = ^{q_in, clr_err};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_load_ctrl.sv
// tb_latch_load_ctrl: self-checking bench for latch_load_ctrl.
// Two instances run side by side: one with default timing and one with
// SETUP=0, EN=1, HOLD=0. A reference model describes each sequence as a cycle
// position counted from the accept edge and derives every output from where
// that position falls in the setup/enable/hold windows.
`timescale 1ns/1ps
module tb_latch_load_ctrl;

  localparam int W   = 4;
  localparam int A_S = 1;
  localparam int A_E = 2;
  localparam int A_H = 1;
  localparam int B_S = 0;
  localparam int B_E = 1;
  localparam int B_H = 0;
`ifdef LATCH_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] q_in = '0;
  logic         clr_err = 1'b0;
  logic         valid_a = 1'b0;
  logic         valid_b = 1'b0;

  logic         ready_a, e_out_a, busy_a, done_a, err_a;
  logic [W-1:0] d_out_a;
  logic         ready_b, e_out_b, busy_b, done_b, err_b;
  logic [W-1:0] d_out_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  latch_load_ctrl #(
    .WIDTH(W), .SETUP_CYCLES(A_S), .EN_CYCLES(A_E), .HOLD_CYCLES(A_H)
  ) dut_a (
    .clk(clk), .rst(rst), .din(din), .valid(valid_a), .ready(ready_a),
    .d_out(d_out_a), .e_out(e_out_a), .busy(busy_a), .done(done_a),
    .q_in(q_in), .clr_err(clr_err), .err(err_a)
  );

  latch_load_ctrl #(
    .WIDTH(W), .SETUP_CYCLES(B_S), .EN_CYCLES(B_E), .HOLD_CYCLES(B_H)
  ) dut_b (
    .clk(clk), .rst(rst), .din(din), .valid(valid_b), .ready(ready_b),
    .d_out(d_out_b), .e_out(e_out_b), .busy(busy_b), .done(done_b),
    .q_in(q_in), .clr_err(clr_err), .err(err_b)
  );

  // Reference model: pos = cycles since the accept edge, -1 when idle.
  typedef struct {
    int           pos;
    logic [W-1:0] d;
    bit           ready;
    bit           done;
    bit           err;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  function automatic mdl_t modelReset();
    mdl_t m;
    m.pos   = -1;
    m.d     = '0;
    m.ready = 1'b0;
    m.done  = 1'b0;
    m.err   = 1'b0;
    return m;
  endfunction

  function automatic mdl_t modelStep(mdl_t m, int s, int e, int h, logic v,
                                     logic [W-1:0] dv, logic [W-1:0] q, logic clr);
    mdl_t n = m;
    int total = s + e + h;
    if (RB) begin
      if (m.pos == s + e - 1 && q != m.d) n.err = 1'b1;
      else if (clr) n.err = 1'b0;
    end
    n.done = 1'b0;
    if (m.pos < 0) begin
      if (v && m.ready) begin
        n.pos = 0;
        n.d   = dv;
      end
    end else begin
      n.pos = m.pos + 1;
      if (n.pos == total) begin
        n.pos  = -1;
        n.done = 1'b1;
      end
    end
    n.ready = (n.pos < 0);
    return n;
  endfunction

  initial begin
    ma = modelReset();
    mb = modelReset();
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = modelReset();
      mb = modelReset();
    end else begin
      ma = modelStep(ma, A_S, A_E, A_H, valid_a, din, q_in, clr_err);
      mb = modelStep(mb, B_S, B_E, B_H, valid_b, din, q_in, clr_err);
    end
  end

  // Table vectors: inputs driven before edge i, expected outputs in cycle i.
  typedef struct {
    logic         valid;
    logic [W-1:0] din;
    logic         ready;
    logic [W-1:0] d;
    logic         e;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t tbl_a[11];
  vec_t tbl_b[5];

  function automatic vec_t mkVec(logic v, logic [W-1:0] dv, logic r, logic [W-1:0] d,
                                 logic e, logic b, logic dn);
    vec_t x;
    x.valid = v; x.din = dv; x.ready = r; x.d = d; x.e = e; x.busy = b; x.done = dn;
    return x;
  endfunction

  task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag, input mdl_t m, input int s, input int e,
                            input logic r, input logic [W-1:0] d, input logic eo,
                            input logic b, input logic dn, input logic er);
    check1({tag, ".ready"}, W'(r), W'(m.ready));
    check1({tag, ".d_out"}, d, m.d);
    check1({tag, ".e_out"}, W'(eo), W'(m.pos >= s && m.pos < s + e));
    check1({tag, ".busy"}, W'(b), W'(m.pos >= 0));
    check1({tag, ".done"}, W'(dn), W'(m.done));
    check1({tag, ".err"}, W'(er), W'(m.err));
  endtask

  task automatic checkOutput();
    checkModel("A", ma, A_S, A_E, ready_a, d_out_a, e_out_a, busy_a, done_a, err_a);
    checkModel("B", mb, B_S, B_E, ready_b, d_out_b, e_out_b, busy_b, done_b, err_b);
  endtask

  task automatic applyStimulus(input logic va, input logic vb, input logic [W-1:0] dv);
    valid_a = va;
    valid_b = vb;
    din     = dv;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  int e_count;

  initial begin
    tbl_a[0]  = mkVec(1'b1, 4'hA, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0);
    tbl_a[1]  = mkVec(1'b0, 4'h3, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0);
    tbl_a[2]  = mkVec(1'b1, 4'h5, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0);
    tbl_a[3]  = mkVec(1'b1, 4'h6, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0);
    tbl_a[4]  = mkVec(1'b0, 4'h7, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
    tbl_a[5]  = mkVec(1'b1, 4'hC, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0);
    tbl_a[6]  = mkVec(1'b0, 4'h1, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0);
    tbl_a[7]  = mkVec(1'b0, 4'h2, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0);
    tbl_a[8]  = mkVec(1'b0, 4'h4, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0);
    tbl_a[9]  = mkVec(1'b0, 4'h8, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1);
    tbl_a[10] = mkVec(1'b0, 4'h9, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);

    tbl_b[0] = mkVec(1'b1, 4'h5, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0);
    tbl_b[1] = mkVec(1'b1, 4'h6, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    tbl_b[2] = mkVec(1'b1, 4'h7, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0);
    tbl_b[3] = mkVec(1'b1, 4'h8, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
    tbl_b[4] = mkVec(1'b0, 4'h9, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput();
    check1("reset.ready", W'(ready_a), W'(1'b0));
    rst = 1'b0;
    stepCycle();
    check1("post_reset.ready", W'(ready_a), W'(1'b1));

    // Default timing table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl_a[i].valid, 1'b0, tbl_a[i].din);
      stepCycle();
      check1($sformatf("tblA[%0d].ready", i), W'(ready_a), W'(tbl_a[i].ready));
      check1($sformatf("tblA[%0d].d_out", i), d_out_a, tbl_a[i].d);
      check1($sformatf("tblA[%0d].e_out", i), W'(e_out_a), W'(tbl_a[i].e));
      check1($sformatf("tblA[%0d].busy", i), W'(busy_a), W'(tbl_a[i].busy));
      check1($sformatf("tblA[%0d].done", i), W'(done_a), W'(tbl_a[i].done));
    end

    // Zero setup/hold table
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, tbl_b[i].valid, tbl_b[i].din);
      stepCycle();
      check1($sformatf("tblB[%0d].ready", i), W'(ready_b), W'(tbl_b[i].ready));
      check1($sformatf("tblB[%0d].d_out", i), d_out_b, tbl_b[i].d);
      check1($sformatf("tblB[%0d].e_out", i), W'(e_out_b), W'(tbl_b[i].e));
      check1($sformatf("tblB[%0d].busy", i), W'(busy_b), W'(tbl_b[i].busy));
      check1($sformatf("tblB[%0d].done", i), W'(done_b), W'(tbl_b[i].done));
    end

    // Back-to-back: valid held high gives an accept every second cycle
    e_count = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, W'(i));
      stepCycle();
      if (e_out_b) e_count++;
    end
    check1("b2b.accepts", W'(e_count), W'(4));
    applyStimulus(1'b0, 1'b0, 4'h0);
    stepCycle();

    // Reset pulsed during ENABLE
    applyStimulus(1'b1, 1'b0, 4'h9);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'h9);
    stepCycle();
    check1("rst_mid.e_before", W'(e_out_a), W'(1'b1));
    #2 rst = 1'b1;
    #1;
    check1("rst_mid.e_out", W'(e_out_a), W'(1'b0));
    check1("rst_mid.d_out", d_out_a, 4'h0);
    check1("rst_mid.busy", W'(busy_a), W'(1'b0));
    check1("rst_mid.ready", W'(ready_a), W'(1'b0));
    @(negedge clk);
    checkOutput();
    check1("rst_mid.no_done", W'(done_a), W'(1'b0));
    rst = 1'b0;
    stepCycle();
    check1("rst_mid.done_after", W'(done_a), W'(1'b0));
    check1("rst_mid.ready_after", W'(ready_a), W'(1'b1));

    // Readback: matching latch keeps err clear
    q_in = 4'h3;
    applyStimulus(1'b1, 1'b0, 4'h3);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'h3);
    repeat (5) stepCycle();
    check1("rb.match_err", W'(err_a), W'(1'b0));

    // Readback: stuck-low latch sets a sticky err, clr_err clears it
    q_in = 4'h0;
    applyStimulus(1'b1, 1'b0, 4'hF);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'hF);
    repeat (5) stepCycle();
    check1("rb.mismatch_err", W'(err_a), W'(RB));
    repeat (3) stepCycle();
    check1("rb.sticky_err", W'(err_a), W'(RB));
    clr_err = 1'b1;
    stepCycle();
    clr_err = 1'b0;
    check1("rb.cleared_err", W'(err_a), W'(1'b0));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
      q_in    = ($urandom_range(0, 7) == 0) ? W'($urandom) : ma.d;
      clr_err = ($urandom_range(0, 9) == 0);
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/latch_load_ctrl.md
Name: latch_load_ctrl

Overview:
- Upstream sequencer for a bank of WIDTH level-sensitive D latches, driving their `d` and `e` inputs.
- Accepts a word over a valid/ready handshake.
- Presents the word on `d_out`, then holds it stable for SETUP_CYCLES before `e_out` opens, EN_CYCLES with `e_out` open, and HOLD_CYCLES after `e_out` closes.
- Pulses `done` when the sequence ends. This guarantees glitch-free, timing-safe latch loading from synchronous logic.

Parameters:
- WIDTH, 4: data and latch-bank width.
- SETUP_CYCLES, 1: cycles `d_out` is stable before `e_out` rises. 0 is legal (phase skipped).
- EN_CYCLES, 2: cycles `e_out` is high. Must be ≥1; elaboration error otherwise.
- HOLD_CYCLES, 1: cycles `d_out` is stable after `e_out` falls. 0 is legal (phase skipped).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- din  input  WIDTH  word to load.
- valid  input  1  `din` is valid.
- ready  output  1  controller can accept a word.
- d_out  output  WIDTH  to latch `d`.
- e_out  output  1  to latch `e`.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence end.
- q_in  input  WIDTH  latch `q` readback. Ignored unless the feature is enabled.
- clr_err  input  1  clears `err`.
- err  output  1  sticky readback mismatch.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rst` is asynchronous and active-high.
  - While `rst` is high: state=IDLE, `d_out`=0, `e_out`=0, `busy`=0, `done`=0, `err`=0, `ready`=0.
  - `ready` rises in the first cycle after `rst` deasserts.
- All outputs are registered. `ready` is `state==IDLE && !rst`.
- State machine: IDLE → SETUP → ENABLE → HOLD → IDLE.
  - SETUP is skipped when SETUP_CYCLES=0; HOLD is skipped when HOLD_CYCLES=0.
  - A single down-counter is loaded with (N−1) on entry to each phase. The phase exits when the counter reaches 0.
- Accept: `valid && ready` sampled at an edge.
  - At that edge, `d_out` <= `din` and the state moves to the first non-skipped phase.
  - `din` is not sampled again until the next accept. `valid` without `ready` is ignored and nothing is queued.
- Outputs per state:
  - `e_out`=1 exactly in ENABLE cycles and never outside ENABLE.
  - `busy`=1 in SETUP, ENABLE and HOLD.
  - `d_out` holds its value from accept through the end of HOLD and keeps it while IDLE.
- `done`:
  - High for the single cycle in which the state is first IDLE after a sequence.
  - `ready` is also high in that cycle, so the next accept can occur at the following edge.
- Timing with defaults, accept at edge 0:
  - cycle 0: SETUP.
  - cycles 1–2: ENABLE, `e_out`=1.
  - cycle 3: HOLD.
  - cycle 4: IDLE, `done`=1.
- Minimum accept-to-accept spacing is SETUP+EN+HOLD+1 cycles.
- Reset mid-sequence: `e_out` drops asynchronously at `rst` assertion, and `d_out` goes to 0. No `done` is issued.
- Counter width is $clog2(max(SETUP,EN,HOLD)+1), minimum 1.

Optional Feature:
- Macro: LATCH_READBACK_EN.
- When defined:
  - `q_in` is compared with `d_out` in the last cycle of the ENABLE phase, when the latch is transparent and settled.
  - A mismatch sets `err` at the next edge. `err` stays set until `clr_err` or `rst`.
  - `clr_err` and a new mismatch at the same edge: the mismatch wins, so `err`=1.
- When undefined: `err` is tied 0, and `q_in` and `clr_err` are unused.

Decomposition:
- Package `latch_ctrl_pkg`:
  - state typedef enum {IDLE, SETUP, ENABLE, HOLD}.
  - default timing constants.
  - function computing the counter width.
- One natural sub-module, `phase_counter`: a loadable down-counter with a zero flag, instantiated once.

Test Plan:
- Defaults, `din`=4'hA, `valid` pulse at edge 0 → `d_out`=A from cycle 0, `e_out`=1 in cycles 1–2 only, `done`=1 in cycle 4, `busy`=1 in cycles 0–3.
- SETUP_CYCLES=0, HOLD_CYCLES=0, EN_CYCLES=1, `din`=4'h5 → `e_out`=1 in cycle 0, `done` in cycle 1; back-to-back `valid` held high gives an accept every 2 cycles.
- `valid` held high with changing `din` during busy → `d_out` is unchanged until the next accept; only the first word latches.
- `rst` pulsed during ENABLE → `e_out` and `d_out` are 0 immediately with no `done`; `ready`=1 the cycle after release.
- LATCH_READBACK_EN, `q_in` tied to the latch model → `err`=0. Force `q_in`=4'h0 while `din`=4'hF → `err`=1 sticky; `clr_err` pulse → `err`=0.
- `valid` asserted in the same cycle as `done` → not accepted until that edge; the new sequence starts exactly one cycle after `done`.
